// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display multiplexer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest number of decimal digits able to show 2**w - 1.
    // The display multiplexer uses the same function for its own DIGITS check.
    function automatic int min_digits(input int w);
        longint lim;
        longint p;
        int     d;
        lim = (longint'(1) << w) - 1;
        p   = 10;
        d   = 1;
        for (int i = 0; i < 20; i++) begin
            if (p <= lim) begin
                p = p * 10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit adjust: adds 3 to a BCD digit of 5 or more, before the shift.
// Latency: combinational.
// Backpressure: none.
// Ports: d = scratch digit in, q = adjusted digit out (4-bit, carry out discarded).
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    assign q = (d >= BCD_DIGIT_W'(5)) ? d + BCD_DIGIT_W'(3) : d;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), feeding the 7-segment display multiplexer.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+W+1; one result per W+1 clocks.
// Backpressure: none; start is ignored while busy, accepted when idle or in the DONE cycle.
//
// Ports:
//   hwclk       system clock, posedge
//   rst_n       asynchronous active-low reset
//   bin_in      W-bit unsigned value, sampled only when start is accepted
//   start       conversion request, level-sampled every clock
//   busy        high while shifting
//   done        one-cycle pulse, bcd_out updated this cycle
//   bcd_out     packed BCD, [3:0] = units, [7:4] = tens, ...
//   blank_mask  present only with LEADING_ZERO_BLANK_EN; bit i set = digit i is a leading zero
//
// Optional feature macro: LEADING_ZERO_BLANK_EN (adds the registered blank_mask output).
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                            hwclk,
    input  logic                            rst_n,
    input  logic [W-1:0]                    bin_in,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]               blank_mask
`endif
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(W + 1);

    if (DIGITS < min_digits(W)) begin : g_digits_check
        $error("bcd_converter: DIGITS too small to represent 2**W-1");
    end

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    shreg;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   scratch_adj;
    logic [BW+W-1:0] cat_sh;
    logic [CW-1:0]   count;
    logic            accept;
    logic            last_shift;
    logic            commit;

    // ---------------- FSM ----------------
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign last_shift = (count == CW'(W - 1));

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        accept   = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                // The finished scratch is committed to bcd_out on leaving DONE, so a
                // back-to-back start here can clear scratch on the same edge safely.
                commit = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_digit u_adj (
            .d (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Adjusted digits and the remaining binary bits shift left together as one word.
    assign cat_sh = {scratch_adj, shreg} << 1;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            scratch <= '0;
            count   <= '0;
        end else if (accept) begin
            shreg   <= bin_in;
            scratch <= '0;
            count   <= '0;
        end else if (state == SHIFT) begin
            scratch <= cat_sh[BW+W-1:W];
            shreg   <= cat_sh[W-1:0];
            count   <= count + CW'(1);
        end
    end

    // ---------------- outputs ----------------
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] mask_nx;

    // Digit i is blank when it and every higher digit are zero; units always shown.
    always_comb begin
        mask_nx = '0;
        for (int i = 1; i < DIGITS; i++) begin
            mask_nx[i] = ((scratch >> (BCD_DIGIT_W * i)) == '0);
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            blank_mask <= ~DIGITS'(1);
        end else if (commit) begin
            blank_mask <= mask_nx;
        end
    end
`endif

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            bcd_out <= '0;
        end else begin
            done <= commit;
            if (commit) begin
                bcd_out <= scratch;
            end
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter (W=8, DIGITS=3).
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_converter;

    logic        hwclk;
    logic        rst_n;
    logic [7:0]  bin_in;
    logic        start;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0]  blank_mask;
`endif

    int total = 0;
    int bad   = 0;

    bcd_converter #(.W(8), .DIGITS(3)) dut (
        .hwclk   (hwclk),
        .rst_n   (rst_n),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .blank_mask (blank_mask)
`endif
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leave the bench 1 ns after the rising edge.
    task automatic step();
        @(posedge hwclk);
        #1;
    endtask

    // Hand-computed packed BCD of a value below 1000.
    function automatic logic [31:0] to_bcd(input int v);
        return 32'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    // One conversion: start for one edge, then scramble bin_in (must not matter).
    // lat = edges from the accepting edge until done is seen; bcnt = busy cycles.
    task automatic run_conv(input int v, output int lat, output int bcnt);
        bin_in = 8'(v);
        start  = 1'b1;
        step();
        start  = 1'b0;
        bin_in = 8'hA5;
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int pulses;
        int first_i;
        int second_i;
        logic [11:0] cap;
        logic [11:0] cap2;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 8'd0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(bcd_out), 32'h000);
`ifdef LEADING_ZERO_BLANK_EN
        chk("rst_mask", 32'(blank_mask), 32'b110);
`endif
        step();
        rst_n = 1'b1;
        step();

        // Zero input.
        run_conv(0, lat, bcnt);
        chk("zero_lat", 32'(lat), 32'd9);
        chk("zero_bcd", 32'(bcd_out), 32'h000);

        // Full-scale input, busy width and single-cycle done.
        run_conv(255, lat, bcnt);
        chk("max_lat",  32'(lat), 32'd9);
        chk("max_busy", 32'(bcnt), 32'd8);
        chk("max_bcd",  32'(bcd_out), 32'h255);
        step();
        chk("max_done_pulse", 32'(done), 32'd0);
        chk("max_hold", 32'(bcd_out), 32'h255);

        // Leading-zero cases.
        run_conv(99, lat, bcnt);
        chk("v99_bcd", 32'(bcd_out), 32'h099);
`ifdef LEADING_ZERO_BLANK_EN
        chk("v99_mask", 32'(blank_mask), 32'b100);
`endif
        run_conv(5, lat, bcnt);
        chk("v5_bcd", 32'(bcd_out), 32'h005);
`ifdef LEADING_ZERO_BLANK_EN
        chk("v5_mask", 32'(blank_mask), 32'b110);
`endif
        step();

        // Start while busy is ignored.
        bin_in = 8'd200;
        start  = 1'b1;
        step();
        start  = 1'b0;
        pulses = 0;
        cap    = '0;
        for (int i = 0; i < 30; i++) begin
            if (i == 3) begin
                bin_in = 8'd7;
                start  = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                pulses++;
                cap = bcd_out;
            end
            step();
        end
        chk("busy_start_bcd",    32'(cap), 32'h200);
        chk("busy_start_pulses", 32'(pulses), 32'd1);

        // Start held high: back-to-back conversions.
        bin_in   = 8'd17;
        start    = 1'b1;
        step();
        bin_in   = 8'd18;
        first_i  = -1;
        second_i = -1;
        cap      = '0;
        cap2     = '0;
        for (int i = 0; i < 26; i++) begin
            if (done) begin
                if (first_i < 0) begin
                    first_i = i;
                    cap     = bcd_out;
                end else if (second_i < 0) begin
                    second_i = i;
                    cap2     = bcd_out;
                end
            end
            step();
        end
        start = 1'b0;
        chk("b2b_first_at", 32'(first_i), 32'd9);
        chk("b2b_period",   32'(second_i - first_i), 32'd9);
        chk("b2b_first",    32'(cap),  32'h017);
        chk("b2b_second",   32'(cap2), 32'h018);
        for (int i = 0; i < 15; i++) step();

        // Reset in the 4th SHIFT cycle.
        bin_in = 8'd123;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd",  32'(bcd_out), 32'h000);
        step();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) pulses++;
            step();
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        chk("abort_bcd_held", 32'(bcd_out), 32'h000);
        run_conv(123, lat, bcnt);
        chk("after_abort_lat", 32'(lat), 32'd9);
        chk("after_abort_bcd", 32'(bcd_out), 32'h123);

        // Full sweep against the decimal reference.
        for (int v = 0; v < 256; v++) begin
            run_conv(v, lat, bcnt);
            chk("sweep_lat", 32'(lat), 32'd9);
            chk("sweep_bcd", 32'(bcd_out), to_bcd(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
